// File: rtl/mem_responder.sv
// Single-port word memory behind a two-state valid/ready responder.
// Optional build macro MEM_ERR_EN adds the registered address-range error output err.
module mem_responder #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  wr_rd,
    input  logic                  valid,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready,
`ifdef MEM_ERR_EN
    output logic                  err,
`endif
    output logic                  dbg_state
);

    // Handshake: a transfer happens at every posedge where valid=1 and ready=1.
    // ready is the state register itself, so it is 1 exactly one cycle after valid=1.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             xfer;
    logic             in_range;
    logic             we;
`ifdef MEM_ERR_EN
    logic             err_q, err_d;
`endif

    always_comb begin
        xfer     = valid && (state_q == ACCESS);
        in_range = ({1'b0, addr} < DEPTH_W);
        state_d  = valid ? ACCESS : IDLE;
        we       = xfer && wr_rd && in_range;
        rdata_d  = rdata_q;
        // Out-of-range reads return zero rather than aliasing into storage.
        if (xfer && !wr_rd) begin
            if (in_range) begin
                rdata_d = mem_q[addr];
            end else begin
                rdata_d = '0;
            end
        end
`ifdef MEM_ERR_EN
        err_d = xfer && !in_range;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
`ifdef MEM_ERR_EN
            err_q   <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
`ifdef MEM_ERR_EN
            err_q   <= err_d;
`endif
            if (we) begin
                mem_q[addr] <= wdata;
            end
        end
    end

    assign ready     = (state_q == ACCESS);
    assign rdata     = rdata_q;
    assign dbg_state = state_q;
`ifdef MEM_ERR_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a behavioural memory model.
// Build with +define+MEM_ERR_EN to also check the err output.
module tb_mem_responder;

    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 24;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  wr_rd;
    logic                  valid;
    logic [WIDTH-1:0]      rdata;
    logic                  ready;
    logic                  err_w;
    logic                  dbg_state;

    mem_responder #(
        .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wdata(wdata),
        .wr_rd(wr_rd),
        .valid(valid),
        .rdata(rdata),
        .ready(ready),
`ifdef MEM_ERR_EN
        .err(err_w),
`endif
        .dbg_state(dbg_state)
    );

`ifndef MEM_ERR_EN
    assign err_w = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    // reference model and scoreboard
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] m_rdata;
    logic             m_ready;
    logic             m_err;
    logic [WIDTH-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies one posedge worth of the specified behaviour to the model.
    task automatic model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            exp_q.delete();
        end else begin
            m_err = 1'b0;
            if (valid && m_ready) begin
                if (int'(addr) < DEPTH) begin
                    if (wr_rd) m_mem[addr] = wdata;
                    else       m_rdata = m_mem[addr];
                end else begin
                    m_err = 1'b1;
                    if (!wr_rd) m_rdata = '0;
                end
                if (!wr_rd) exp_q.push_back(m_rdata);
            end
            m_ready = valid;
        end
    endtask

    // One clock: model update at the edge, then compare outputs 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("ready", 32'(ready), 32'(m_ready));
        check("rdata_hold", 32'(rdata), 32'(m_rdata));
        if (exp_q.size() > 0) check("rd_data", 32'(rdata), 32'(exp_q.pop_front()));
`ifdef MEM_ERR_EN
        check("err", 32'(err_w), 32'(m_err));
`endif
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic w, input logic [ADDR_WIDTH-1:0] a,
                         input logic [WIDTH-1:0] d);
        valid = v;
        wr_rd = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    logic [WIDTH-1:0] vals [4];

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        m_ready = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;

        // reset, then first valid in cycle 3
        do_reset(2);
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        tick();
        drive(1'b1, 1'b0, 5'd0, '0);
        check("c3_ready", 32'(ready), 32'h0);
        tick();
        check("c4_ready", 32'(ready), 32'h1);

        // write 5 then read 5
        drive(1'b1, 1'b1, 5'd5, 16'hA5A5);
        tick();
        drive(1'b1, 1'b0, 5'd5, '0);
        tick();
        check("rd5", 32'(rdata), 32'h0000A5A5);
        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();

        // back-to-back writes 0..3 then reads 0..3 with valid held
        for (int i = 0; i < 4; i++) vals[i] = WIDTH'($urandom);
        drive(1'b1, 1'b1, 5'd0, vals[0]);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, ADDR_WIDTH'(i), vals[i]);
            tick();
            check("b2b_wr_ready", 32'(ready), 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, ADDR_WIDTH'(i), '0);
            tick();
            check("b2b_rd_ready", 32'(ready), 32'h1);
            check("b2b_rd_data", 32'(rdata), 32'(vals[i]));
        end

        // out-of-range write and read at 30, memory must not alias
        drive(1'b1, 1'b1, 5'd30, 16'hBEEF);
        tick();
        drive(1'b1, 1'b0, 5'd30, '0);
        tick();
        check("oor_rdata", 32'(rdata), 32'h0);
`ifdef MEM_ERR_EN
        check("oor_err", 32'(err_w), 32'h1);
`endif
        drive(1'b1, 1'b0, 5'd6, '0);
        tick();
        check("alias6", 32'(rdata), 32'h0);
`ifdef MEM_ERR_EN
        check("oor_err_clear", 32'(err_w), 32'h0);
`endif
        drive(1'b1, 1'b0, 5'd5, '0);
        tick();
        check("keep5", 32'(rdata), 32'h0000A5A5);

        // reset mid-burst after writing addr 2
        drive(1'b1, 1'b1, 5'd2, 16'h1234);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd2, '0);
        tick();
        check("postrst_ready", 32'(ready), 32'h1);
        tick();
        check("postrst_rd2", 32'(rdata), 32'h0);
        drive(1'b0, 1'b0, '0, '0);
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ADDR_WIDTH'($urandom_range(0, 31)), WIDTH'($urandom));
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 24, meaning number of implemented words (1..2**ADDR_WIDTH).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on posedge clk.
REQ-005 The block SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-006 The block SHALL have port addr, input, ADDR_WIDTH, meaning word address from the initiator.
REQ-007 The block SHALL have port wdata, input, WIDTH, meaning write data.
REQ-008 The block SHALL have port wr_rd, input, 1, meaning 1 = write, 0 = read.
REQ-009 The block SHALL have port valid, input, 1, meaning the initiator request qualifier.
REQ-010 The block SHALL have port rdata, output, WIDTH, meaning registered read data.
REQ-011 The block SHALL have port ready, output, 1, meaning the registered responder acknowledge.
REQ-012 The block SHALL have port err, output, 1, meaning address-range error, present only under MEM_ERR_EN (REQ-027).

Function
REQ-013 The block SHALL contain DEPTH x WIDTH storage, with every word zero after reset, so rdata is never X.
REQ-014 The FSM SHALL have two states, IDLE (ready=0) and ACCESS (ready=1), with ready driven directly from the state register.
REQ-015 In IDLE, valid=1 at a posedge SHALL move the FSM to ACCESS; valid=0 SHALL hold IDLE.
REQ-016 In ACCESS, valid=1 at a posedge SHALL hold ACCESS; valid=0 SHALL return to IDLE.
REQ-017 Consequence of REQ-015/016: ready SHALL be 1 exactly one cycle after every cycle in which valid=1, and 0 one cycle after valid=0.
REQ-018 A transfer SHALL occur at each posedge where valid=1 and ready=1, with exactly one transfer per such edge.
REQ-019 A write transfer (wr_rd=1) with addr<DEPTH SHALL store wdata into mem[addr] at that edge.
REQ-020 A read transfer (wr_rd=0) with addr<DEPTH SHALL load mem[addr] into rdata at that edge, making it visible 1 cycle after the handshake.
REQ-021 rdata SHALL hold its value in all cycles without a read transfer.
REQ-022 A read transfer to an address written by the immediately preceding transfer SHALL return the new data, with no stale read.
REQ-023 A transfer with addr>=DEPTH SHALL leave memory unchanged, and a read SHALL load rdata with 0.
REQ-024 The initiator SHALL hold addr, wdata and wr_rd stable while valid=1 and ready=0; the block SHALL sample them only at transfer edges.

Reset
REQ-025 With rst=1 at a posedge, the block SHALL set the state to IDLE, ready=0, rdata=0, err=0 and every memory word to 0; any transfer coincident with reset SHALL be discarded.
REQ-026 After rst deasserts, the first ready=1 SHALL appear no earlier than one cycle after the first sampled valid=1, including when reset is asserted mid-burst.

Configuration
REQ-027 With macro MEM_ERR_EN defined, port err SHALL exist, and err SHALL be registered to 1 for the cycle after any transfer with addr>=DEPTH, 0 otherwise.
REQ-028 Without MEM_ERR_EN, port err SHALL be absent, and out-of-range transfers SHALL still behave per REQ-023 silently.

Verification
REQ-029 Bench SHALL cover: reset, then valid=1 in cycle 3 -> ready=0 in cycle 3, ready=1 in cycle 4.
REQ-030 Bench SHALL cover: write addr=5 wdata=16'hA5A5 handshake, then read addr=5 -> rdata=16'hA5A5 one cycle after the read handshake.
REQ-031 Bench SHALL cover: valid held high for 4 back-to-back writes to addr 0..3, then 4 reads -> ready stays 1 throughout, and reads return the written values in order.
REQ-032 Bench SHALL cover: read of addr=30 with DEPTH=24 -> rdata=0, memory unchanged, and err=1 for one cycle under MEM_ERR_EN.
REQ-033 Bench SHALL cover: rst=1 mid-burst after writing addr=2 -> ready=0 next cycle, and a post-reset read of addr=2 returns 0.
REQ-034 Bench SHALL cover: random traffic with checker properties bound -> ready follows valid by exactly 1 cycle, rdata never X, and no assertion failures.
